// File: rtl/cpu_pkg.sv
// Shared load/store encodings: funct3 size codes, FSM states, access legality check.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Stores only decode the size bits, so 1xx aliases onto 0xx; loads use
  // bit 2 as the unsigned flag and only the five listed codes exist.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic code_ok;
    logic align_ok;
    if (is_store) code_ok = (f3[1:0] != 2'b11);
    else          code_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                            (f3 == F3_BU) || (f3 == F3_HU);
    case (f3[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~off[0];
      2'b10:   align_ok = (off == 2'b00);
      default: align_ok = 1'b0;
    endcase
    return code_ok && align_ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: rdata (read word), off (byte offset), funct3 (size/sign), data (result).
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[8*off +: 8];
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'h0, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'h0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: drives a word-wide ready-handshaked data bus and extends load data.
// Latency: >=2 stalled cycles (detect + REQ until mem_ready), then one DONE cycle.
// Backpressure: Stall holds the core while in REQ; mem_ready absence aborts after TIMEOUT.
// Ports: MemRead/MemWrite/funct3/ALUResult/ReadData2 from the ALU stage; MemData,
// Stall, AccessFault, BusErr to the core; mem_* is the data-memory bus.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  output logic [31:0] MemData,
  output logic        Stall,
  output logic        AccessFault,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic             load_q;

  logic        valid;
  logic        legal;
  logic        start;
  logic [1:0]  off;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] ext_data;

  assign off   = ALUResult[1:0];
  assign valid = MemRead | MemWrite;
  // A simultaneous read+write request is treated as a store.
  assign legal = access_legal(MemWrite, funct3, off);
  assign start = (state == ST_IDLE) && valid && legal;
  assign Stall = start || (state == ST_REQ);

  // Lane steering: narrow data is replicated across the word so the byte
  // enables alone pick the target lanes.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << off;
        wdata_next = {4{ReadData2[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << off;
        wdata_next = {2{ReadData2[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = ReadData2;
      end
    endcase
  end

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      load_q      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      MemData     <= '0;
      AccessFault <= 1'b0;
      BusErr      <= 1'b0;
    end else begin
      AccessFault <= 1'b0;
      BusErr      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid) begin
            if (legal) begin
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {ALUResult[31:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
              off_q     <= off;
              f3_q      <= funct3;
              load_q    <= ~MemWrite;
              cnt       <= '0;
              state     <= ST_REQ;
            end else begin
              AccessFault <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (load_q) MemData <= ext_data;
            state <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // This cycle is the TIMEOUT-th REQ cycle without a response.
            mem_req <= 1'b0;
            BusErr  <= 1'b1;
            MemData <= '0;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: randomized load/store traffic with a scoreboard.
// Latency: n/a.
// Backpressure: bench memory inserts random wait states and occasional no-response.
module tb_mem_access_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, ReadData2;
  logic [31:0] MemData;
  logic        Stall, AccessFault, BusErr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          fault;
    bit          is_load;
    logic [31:0] addr;
    logic [3:0]  be;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] memdata;
    bit          buserr;
    int          stall;
  } exp_t;

  typedef struct {
    int          wait_n;   // -1: never respond
    logic [31:0] rdata;
  } resp_t;

  exp_t  exp_q[$];
  resp_t resp_q[$];

  mem_access_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .ReadData2(ReadData2),
    .MemData(MemData), .Stall(Stall), .AccessFault(AccessFault), .BusErr(BusErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outcome of one instruction, from the access rules.
  function automatic exp_t model(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] rd2,
                                 input int wait_n, input logic [31:0] rdata);
    exp_t e;
    int off, sz, v;
    bit code_ok, align_ok;
    logic [31:0] b, h;
    e = '{fault:0, is_load:0, addr:0, be:0, we:0, wdata:0, memdata:0, buserr:0, stall:0};
    off = int'(addr % 32'd4);
    sz  = int'(f3 % 3'd4);
    if (wr) code_ok = (sz != 3);
    else    code_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    align_ok = (sz == 0) || (sz == 1 && off % 2 == 0) || (sz == 2 && off == 0);
    e.is_load = !wr;
    if (!(rd || wr) || !(code_ok && align_ok)) begin
      e.fault = 1;
      return e;
    end
    e.we    = wr;
    e.addr  = addr - 32'(off);
    e.be    = 4'((sz == 0) ? (1 << off) : (sz == 1) ? (3 << off) : 15);
    e.wdata = (sz == 0) ? (rd2 % 256) * 32'h01010101 :
              (sz == 1) ? (rd2 % 65536) * 32'h00010001 : rd2;
    if (wait_n < 0) begin
      e.buserr  = 1;
      e.memdata = 0;
      e.stall   = 1 + TO;
    end else begin
      e.stall = wait_n + 2;
      b = (rdata >> (8 * off)) % 256;
      h = (rdata >> (16 * (off / 2))) % 65536;
      case (f3)
        3'd0: begin v = (b >= 128) ? int'(b) - 256 : int'(b); e.memdata = 32'(v); end
        3'd1: begin v = (h >= 32768) ? int'(h) - 65536 : int'(h); e.memdata = 32'(v); end
        3'd4: e.memdata = b;
        3'd5: e.memdata = h;
        default: e.memdata = rdata;
      endcase
    end
    return e;
  endfunction

  task automatic idle_inputs();
    MemRead = 0; MemWrite = 0; funct3 = 0; ALUResult = 0; ReadData2 = 0;
  endtask

  // Called #1 after a posedge with the DUT in IDLE; returns the same way.
  task automatic do_txn(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rd2,
                        input int wait_n, input logic [31:0] rdata);
    exp_t  e;
    resp_t r;
    int    k;
    e = model(rd, wr, f3, addr, rd2, wait_n, rdata);
    exp_q.push_back(e);
    if (!e.fault) begin
      r.wait_n = wait_n; r.rdata = rdata;
      resp_q.push_back(r);
    end
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; ReadData2 = rd2;
    if (e.fault) begin
      @(posedge clk); #1;
    end else begin
      k = 0;
      do begin
        @(posedge clk); #1; k++;
      end while (Stall && k < 60);
      if (Stall) begin
        n_tests++; n_fail++;
        $display("FAIL txn_bound: Stall still 1 after %0d cycles, required 0", k);
      end
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  // Bench memory: random wait states per request; random mem_ready noise when idle.
  initial begin
    resp_t r;
    bit    active;
    int    cnt;
    active = 0; cnt = 0; r.wait_n = -1; r.rdata = 0;
    mem_ready = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0; mem_ready = 0;
      end else if (mem_req) begin
        if (!active) begin
          if (resp_q.size() > 0) r = resp_q.pop_front();
          else begin r.wait_n = -1; r.rdata = 0; end
          active = 1; cnt = 0;
        end
        if (r.wait_n >= 0 && cnt == r.wait_n) begin
          mem_ready = 1; mem_rdata = r.rdata;
        end else begin
          mem_ready = 0; mem_rdata = $urandom;
        end
        cnt++;
      end else begin
        active = 0;
        mem_ready = 1'($urandom % 2);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: compares observed transactions against the scoreboard queue.
  initial begin
    exp_t        e;
    int          stall_cnt;
    bit          prev_stall, prev_req, prev_af, prev_be, stable;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    stall_cnt = 0; prev_stall = 0; prev_req = 0; prev_af = 0; prev_be = 0; stable = 1;
    c_addr = 0; c_wdata = 0; c_be = 0; c_we = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_cnt = 0; prev_stall = 0; prev_req = 0; prev_af = 0; prev_be = 0; stable = 1;
      end else begin
        if (prev_af) check("af_pulse_len", 32'(AccessFault), 0);
        if (prev_be) check("buserr_pulse_len", 32'(BusErr), 0);
        if (AccessFault && !prev_af) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_fault: AccessFault 1 with empty scoreboard");
          end else begin
            e = exp_q.pop_front();
            check("fault_expected", 1, 32'(e.fault));
            check("fault_no_req", 32'(mem_req), 0);
            check("fault_no_stall", 32'(prev_stall), 0);
          end
        end
        if (Stall) stall_cnt++;
        if (mem_req && !prev_req) begin
          c_addr = mem_addr; c_wdata = mem_wdata; c_be = mem_be; c_we = mem_we; stable = 1;
        end else if (mem_req) begin
          if (mem_addr !== c_addr || mem_wdata !== c_wdata || mem_be !== c_be || mem_we !== c_we)
            stable = 0;
        end
        if (prev_stall && !Stall) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_done: access completed with empty scoreboard");
          end else begin
            e = exp_q.pop_front();
            check("done_not_fault", 32'(e.fault), 0);
            check("bus_addr", c_addr, e.addr);
            check("bus_we", 32'(c_we), 32'(e.we));
            check("bus_be", 32'(c_be), 32'(e.be));
            if (e.we) check("bus_wdata", c_wdata, e.wdata);
            check("bus_stable", 32'(stable), 1);
            check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
            check("buserr", 32'(BusErr), 32'(e.buserr));
            check("req_dropped", 32'(mem_req), 0);
            if (e.is_load || e.buserr) check("memdata", MemData, e.memdata);
          end
          stall_cnt = 0;
        end
        prev_stall = Stall; prev_req = mem_req; prev_af = AccessFault; prev_be = BusErr;
      end
    end
  end

  // Stimulus
  initial begin
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          w, sel;
    rst_n = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", 32'(mem_be), 0);
    check("rst_memdata", MemData, 0);
    check("rst_fault", 32'(AccessFault), 0);
    check("rst_buserr", 32'(BusErr), 0);
    check("rst_stall", 32'(Stall), 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Directed cases
    do_txn(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);   // lw
    do_txn(1, 0, 3'b000, 32'h203, 32'h0, 1, 32'h80112233);   // lb
    do_txn(1, 0, 3'b100, 32'h203, 32'h0, 0, 32'h80112233);   // lbu
    do_txn(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 3, 32'h0);   // sh
    do_txn(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0);          // misaligned lw
    do_txn(1, 0, 3'b110, 32'h100, 32'h0, 0, 32'h0);          // illegal load code
    do_txn(0, 1, 3'b011, 32'h100, 32'h0, 0, 32'h0);          // illegal store size
    do_txn(1, 0, 3'b010, 32'h300, 32'h0, -1, 32'h0);         // timeout
    do_txn(1, 1, 3'b000, 32'h3, 32'h5A, 0, 32'h0);           // both high -> store
    do_txn(1, 0, 3'b101, 32'h202, 32'h0, 2, 32'h8765F00D);   // lhu upper half
    do_txn(1, 0, 3'b001, 32'h202, 32'h0, 0, 32'h8765F00D);   // lh upper half

    // Reset in the middle of REQ
    exp_q.push_back(model(1, 0, 3'b010, 32'h80, 0, -1, 0));
    resp_q.push_back('{wait_n: -1, rdata: 0});
    MemRead = 1; funct3 = 3'b010; ALUResult = 32'h80;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #3;
    check("mid_req_active", 32'(mem_req), 1);
    rst_n = 0;
    #1;
    check("rst_drops_req", 32'(mem_req), 0);
    check("rst_stall", 32'(Stall), 0);
    exp_q.delete();
    resp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_idle_req", 32'(mem_req), 0);
    do_txn(0, 1, 3'b010, 32'h40, 32'h12345678, 1, 32'h0);    // sw after reset

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      sel  = $urandom % 3;
      rd   = (sel != 1);
      wr   = (sel != 0);
      f3   = 3'($urandom % 8);
      addr = $urandom;
      if ($urandom % 2 == 0) addr[1:0] = 2'b00;
      w    = ($urandom % 12 == 0) ? -1 : int'($urandom % 5);
      do_txn(rd, wr, f3, addr, $urandom, w, $urandom);
    end

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
